// File: rtl/load_store_unit.sv
// load_store_unit: runs one data-bus transaction per LOAD/STORE and returns aligned, extended load data
// Ports: clk/reset (sync, active-high); start/opcode/funct3/address/store_data request in;
//        busy/done/load_data/misaligned/bus_error result out; mem_* data-bus master with mem_ack/mem_rdata in.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [31:0] address,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] load_data,
  output logic        misaligned,
  output logic        bus_error,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  typedef enum logic [1:0] {IDLE, REQ, RESP, FAULT} state_t;
  state_t state, state_d;
  logic [31:0] cnt;
  logic [2:0]  f3;
  logic [1:0]  off;
  logic [31:0] lane;
  logic        is_ld, is_st, accept, illegal, misal, tmo;
  assign is_ld = opcode == OP_LOAD;
  assign is_st = opcode == OP_STORE;
  assign accept = start && state == IDLE && (is_ld || is_st);
  // size code 11 is never legal; bit 2 is only legal for LBU/LHU
  assign illegal = funct3[1:0] == 2'b11 || (funct3[2] && (is_st || funct3[1]));
  assign misal = (funct3[1:0] == 2'b01 && address[0]) || (funct3[1:0] == 2'b10 && address[1:0] != 2'b00);
  // an ack arriving on the final allowed cycle completes normally
  assign tmo = TIMEOUT_CYCLES != 0 && state == REQ && !mem_ack && cnt == 32'(TIMEOUT_CYCLES - 1);
  assign lane = mem_rdata >> {off, 3'b000};
  assign busy = state != IDLE;
  assign done = state == RESP || state == FAULT;
  assign mem_req = state == REQ;
  always_comb begin
    state_d = state;
    if (accept) state_d = (illegal || misal) ? FAULT : REQ;
    else if (state == REQ && (mem_ack || tmo)) state_d = RESP;
    else if (done) state_d = IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      f3 <= '0;
      off <= '0;
      misaligned <= 1'b0;
      bus_error <= 1'b0;
      load_data <= '0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wmask <= '0;
      mem_wdata <= '0;
    end else begin
      state <= state_d;
      cnt <= (state == REQ && state_d == REQ) ? cnt + 32'd1 : '0;
      misaligned <= accept && !illegal && misal;
      bus_error <= (accept && illegal) || tmo;
      if (accept) begin
        f3 <= funct3;
        off <= address[1:0];
        mem_we <= is_st;
        mem_addr <= {address[31:2], 2'b00};
        mem_wmask <= !is_st ? 4'b0000 : funct3[1] ? 4'b1111 : funct3[0] ? 4'b0011 << address[1:0] : 4'b0001 << address[1:0];
        mem_wdata <= funct3[1] ? store_data : funct3[0] ? {2{store_data[15:0]}} : {4{store_data[7:0]}};
      end
      if (state == REQ && mem_ack && !mem_we)
        load_data <= f3[1:0] == 2'b10 ? lane :
                     f3[0] ? {{16{~f3[2] & lane[15]}}, lane[15:0]} :
                     {{24{~f3[2] & lane[7]}}, lane[7:0]};
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: table, hand-written and randomized checks of load_store_unit against a byte-level model
module tb_load_store_unit;
  localparam int TO = 4;
  localparam logic [6:0] LD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011;
  logic clk = 0, reset, start, busy, done, misaligned, bus_error, mem_req, mem_we, mem_ack;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [31:0] address, store_data, load_data, mem_addr, mem_wdata, mem_rdata;
  logic [3:0] mem_wmask;
  int total = 0, bad = 0;
  logic [31:0] cur_ld;
  typedef struct {
    logic [6:0] op; logic [2:0] f3; logic [31:0] addr, sd; int d; logic [31:0] rd;
    int dc, rc; logic mis, err; logic [31:0] ld; logic [3:0] mask; logic [31:0] wd;
  } vec_t;
  vec_t tbl[14];
  always #5 clk = ~clk;
  load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode), .funct3(funct3),
    .address(address), .store_data(store_data), .busy(busy), .done(done),
    .load_data(load_data), .misaligned(misaligned), .bus_error(bus_error),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wmask(mem_wmask),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask
  function automatic vec_t model(input vec_t v, input logic [31:0] prev);
    int sz = 1 << v.f3[1:0];
    int off = int'(v.addr % 4);
    bit ld_op = v.op == LD;
    bit legal = ld_op ? (v.f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (v.f3 <= 3'd2);
    logic [31:0] val = '0;
    v.ld = prev; v.mis = 0; v.err = 0; v.mask = '0; v.wd = '0;
    for (int i = 0; i < 4; i++) begin
      if (!ld_op && i >= off && i < off + sz) v.mask[i] = 1'b1;
      v.wd[8*i +: 8] = v.sd[8*(i % sz) +: 8];
    end
    if (!legal) begin v.err = 1; v.dc = 1; v.rc = 0; end
    else if (off % sz != 0) begin v.mis = 1; v.dc = 1; v.rc = 0; end
    else if (v.d + 1 > TO) begin v.err = 1; v.rc = TO; v.dc = TO + 1; end
    else begin
      v.rc = v.d + 1; v.dc = v.d + 2;
      if (ld_op) begin
        for (int i = 0; i < sz; i++) val[8*i +: 8] = v.rd[8*(off+i) +: 8];
        if (!v.f3[2] && sz < 4 && v.rd[8*(off+sz)-1])
          for (int i = sz; i < 4; i++) val[8*i +: 8] = 8'hFF;
        v.ld = val;
      end
    end
    return v;
  endfunction
  task automatic run(input vec_t v, input string tag);
    int dc = 0, rc = 0;
    logic mis = 0, err = 0;
    logic [31:0] ld = '0;
    @(negedge clk);
    start = 1; opcode = v.op; funct3 = v.f3; address = v.addr; store_data = v.sd; mem_ack = 0;
    @(negedge clk);
    start = 0; funct3 = 3'($urandom); address = $urandom; store_data = $urandom;
    for (int c = 1; c <= 20 && dc == 0; c++) begin
      chk({tag, " overlap"}, 32'(done & mem_req), 0);
      if (mem_req) begin
        rc++;
        chk({tag, " addr"}, mem_addr, v.addr & ~32'h3);
        chk({tag, " we"}, 32'(mem_we), 32'(v.op == ST));
        chk({tag, " mask"}, 32'(mem_wmask), 32'(v.mask));
        if (v.op == ST) chk({tag, " wdata"}, mem_wdata, v.wd);
      end
      if (done) begin
        dc = c; mis = misaligned; err = bus_error; ld = load_data;
      end else chk({tag, " flags_idle"}, {misaligned, bus_error}, 0);
      mem_ack = mem_req && rc == v.d + 1;
      mem_rdata = mem_ack ? v.rd : $urandom;
      @(negedge clk);
    end
    mem_ack = 0;
    chk({tag, " done_cycle"}, dc, v.dc);
    chk({tag, " req_cycles"}, rc, v.rc);
    chk({tag, " misaligned"}, 32'(mis), 32'(v.mis));
    chk({tag, " bus_error"}, 32'(err), 32'(v.err));
    chk({tag, " load_data"}, ld, v.ld);
    chk({tag, " busy_after"}, 32'(busy), 0);
  endtask
  initial begin
    vec_t v;
    reset = 1; start = 0; opcode = 0; funct3 = 0; address = 0; store_data = 0; mem_ack = 0; mem_rdata = 0;
    repeat (2) @(negedge clk);
    chk("rst busy", 32'(busy), 0);
    chk("rst done", 32'(done), 0);
    chk("rst req", 32'(mem_req), 0);
    chk("rst flags", {misaligned, bus_error, mem_we}, 0);
    chk("rst load_data", load_data, 0);
    chk("rst addr", mem_addr, 0);
    chk("rst mask", 32'(mem_wmask), 0);
    reset = 0;
    tbl[0]  = '{LD, 3'd2, 32'h100, 32'h0, 0, 32'hDEADBEEF, 2, 1, 0, 0, 32'hDEADBEEF, 4'h0, 32'h0};
    tbl[1]  = '{LD, 3'd0, 32'h103, 32'h0, 0, 32'h80112233, 2, 1, 0, 0, 32'hFFFFFF80, 4'h0, 32'h0};
    tbl[2]  = '{LD, 3'd4, 32'h103, 32'h0, 0, 32'h80112233, 2, 1, 0, 0, 32'h00000080, 4'h0, 32'h0};
    tbl[3]  = '{LD, 3'd5, 32'h102, 32'h0, 0, 32'h80112233, 2, 1, 0, 0, 32'h00008011, 4'h0, 32'h0};
    tbl[4]  = '{ST, 3'd1, 32'h202, 32'h1234ABCD, 3, 32'h0, 5, 4, 0, 0, 32'h00008011, 4'hC, 32'hABCDABCD};
    tbl[5]  = '{LD, 3'd2, 32'h101, 32'h0, 0, 32'h0, 1, 0, 1, 0, 32'h00008011, 4'h0, 32'h0};
    tbl[6]  = '{LD, 3'd3, 32'h100, 32'h0, 0, 32'h0, 1, 0, 0, 1, 32'h00008011, 4'h0, 32'h0};
    tbl[7]  = '{LD, 3'd2, 32'h104, 32'h0, 10, 32'h55555555, 5, 4, 0, 1, 32'h00008011, 4'h0, 32'h0};
    tbl[8]  = '{LD, 3'd2, 32'h108, 32'h0, 3, 32'hCAFEF00D, 5, 4, 0, 0, 32'hCAFEF00D, 4'h0, 32'h0};
    tbl[9]  = '{ST, 3'd0, 32'h301, 32'hA5, 1, 32'h0, 3, 2, 0, 0, 32'hCAFEF00D, 4'h2, 32'hA5A5A5A5};
    tbl[10] = '{LD, 3'd1, 32'h102, 32'h0, 0, 32'h80010000, 2, 1, 0, 0, 32'hFFFF8001, 4'h0, 32'h0};
    tbl[11] = '{ST, 3'd4, 32'h300, 32'h0, 0, 32'h0, 1, 0, 0, 1, 32'hFFFF8001, 4'h0, 32'h0};
    tbl[12] = '{ST, 3'd2, 32'h300, 32'h11223344, 0, 32'h0, 2, 1, 0, 0, 32'hFFFF8001, 4'hF, 32'h11223344};
    tbl[13] = '{ST, 3'd1, 32'h301, 32'h0, 0, 32'h0, 1, 0, 1, 0, 32'hFFFF8001, 4'h0, 32'h0};
    for (int i = 0; i < 14; i++) run(tbl[i], $sformatf("vec%0d", i));
    @(negedge clk);
    start = 1; opcode = LD; funct3 = 3'd2; address = 32'h400;
    @(negedge clk);
    start = 0;
    chk("rstreq req", 32'(mem_req), 1);
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    chk("rstreq req", 32'(mem_req), 0);
    chk("rstreq busy", 32'(busy), 0);
    chk("rstreq done", 32'(done), 0);
    reset = 0;
    repeat (3) begin
      @(negedge clk);
      chk("rstreq idle_done", 32'(done), 0);
      chk("rstreq idle_busy", 32'(busy), 0);
    end
    start = 1; opcode = LD; funct3 = 3'd2; address = 32'h500;
    @(negedge clk);
    opcode = ST; funct3 = 3'd2; address = 32'h600; store_data = 32'hFFFFFFFF;
    chk("busyign busy", 32'(busy), 1);
    @(negedge clk);
    start = 0;
    chk("busyign we", 32'(mem_we), 0);
    chk("busyign addr", mem_addr, 32'h500);
    mem_ack = 1; mem_rdata = 32'h12345678;
    @(negedge clk);
    mem_ack = 0;
    chk("busyign done", 32'(done), 1);
    chk("busyign ld", load_data, 32'h12345678);
    repeat (2) begin
      @(negedge clk);
      chk("busyign idle", {busy, mem_req}, 0);
    end
    start = 1; opcode = 7'b0110011; funct3 = 3'd2; address = 32'h700; mem_ack = 1;
    @(negedge clk);
    start = 0;
    chk("badop busy", 32'(busy), 0);
    chk("badop req", 32'(mem_req), 0);
    @(negedge clk);
    mem_ack = 0;
    chk("badop done", 32'(done), 0);
    cur_ld = 32'h12345678;
    for (int i = 0; i < 150; i++) begin
      v.op = ($urandom_range(0, 1) != 0) ? LD : ST;
      v.f3 = 3'($urandom);
      v.addr = $urandom;
      v.sd = $urandom;
      v.rd = $urandom;
      v.d = $urandom_range(0, 5);
      v = model(v, cur_ld);
      run(v, $sformatf("rnd%0d", i));
      cur_ld = v.ld;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
